sram_axi_bridge: RTL and testbench

- Sits directly downstream of the CPU core.
- Converts the core's two SRAM-like ports (instruction read-only, data read/write) into one AXI3 master.
- Allows at most one outstanding read and one outstanding write.
- Data-port reads are prioritised over instruction fetches. Data-port read/write interleaving is ordered so data_ok responses never collide.

---
 rtl/sram_axi_bridge_pkg.sv | 21 ++
 rtl/sram_axi_bridge_if.sv | 96 +++++++++
 rtl/sram_axi_bridge_axi_wr_ctrl.sv | 83 ++++++++
 rtl/sram_axi_bridge.sv | 116 +++++++++++
 tb/tb_sram_axi_bridge.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge.
package sram_axi_bridge_pkg;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

   localparam logic [3:0] DEF_INST_ID = 4'd0;
   localparam logic [3:0] DEF_DATA_ID = 4'd1;

   // Single-beat incrementing bursts, no lock/cache/protection attributes.
   localparam logic [7:0] AXI_LEN   = 8'd0;
   localparam logic [1:0] AXI_BURST = 2'b01;
   localparam logic [1:0] AXI_LOCK  = 2'b00;
   localparam logic [3:0] AXI_CACHE = 4'd0;
   localparam logic [2:0] AXI_PROT  = 3'd0;

   function automatic logic [2:0] axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Core-side SRAM ports and AXI3 master channels of the bridge; master = bridge view.
interface sram_axi_bridge_if;
   logic        inst_sram_req;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      input  inst_sram_req, inst_sram_size, inst_sram_addr,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
      input  data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output inst_sram_req, inst_sram_size, inst_sram_addr,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
      output data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/sram_axi_bridge_axi_wr_ctrl.sv
// Single-outstanding AXI write engine: latches one data-port store and drives AW/W/B.
module sram_axi_bridge_axi_wr_ctrl
   import sram_axi_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        acc,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   output logic        idle,
   output logic        done,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   wr_state_t state, state_next;
   logic      aw_done, w_done;
   logic [1:0] size_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= W_IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         awaddr  <= '0;
         size_q  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
      end else begin
         state <= state_next;
         if (acc) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            awaddr  <= req_addr;
            size_q  <= req_size;
            wdata   <= req_wdata;
            wstrb   <= req_wstrb;
         end else if (state == W_ADDR) begin
            // AW and W complete independently; each valid drops after its own handshake.
            if (awready) aw_done <= 1'b1;
            if (wready)  w_done  <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      awvalid    = 1'b0;
      wvalid     = 1'b0;
      bready     = 1'b0;
      done       = 1'b0;
      case (state)
         W_IDLE: if (acc) state_next = W_ADDR;
         W_ADDR: begin
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done | awready) & (w_done | wready)) state_next = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               done       = 1'b1;
               state_next = W_IDLE;
            end
         end
         default: state_next = W_IDLE;
      endcase
   end

   assign idle   = (state == W_IDLE);
   assign awsize = axi_size(size_q);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM ports onto one AXI3 master (one read, one write in flight).
module sram_axi_bridge
   import sram_axi_bridge_pkg::*;
#(
   parameter logic [3:0] INST_ID = DEF_INST_ID,
   parameter logic [3:0] DATA_ID = DEF_DATA_ID
)(
   input logic               clk,
   input logic               reset,
   sram_axi_bridge_if.master bus
);

   rd_state_t   r_state, r_next;
   logic        r_owner_data;
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        d_rd_acc, d_wr_acc, i_acc, r_hit;
   logic        w_idle, w_done;
   logic        unused_axi;

   assign unused_axi = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

   // Reads wait for an idle write path (RAW); writes wait out any data read so data_ok never collides.
   always_comb begin
      d_rd_acc = ~reset & bus.data_sram_req & ~bus.data_sram_wr & (r_state == R_IDLE) & w_idle;
      d_wr_acc = ~reset & bus.data_sram_req & bus.data_sram_wr & w_idle
                 & ~((r_state != R_IDLE) & r_owner_data);
      i_acc    = ~reset & bus.inst_sram_req & (r_state == R_IDLE) & ~d_rd_acc;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= R_IDLE;
         r_owner_data <= 1'b0;
         r_addr       <= '0;
         r_size       <= '0;
      end else begin
         r_state <= r_next;
         if (d_rd_acc | i_acc) begin
            r_owner_data <= d_rd_acc;
            r_addr       <= d_rd_acc ? bus.data_sram_addr : bus.inst_sram_addr;
            r_size       <= d_rd_acc ? bus.data_sram_size : bus.inst_sram_size;
         end
      end
   end

   always_comb begin
      r_next      = r_state;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      r_hit       = 1'b0;
      case (r_state)
         R_IDLE: if (d_rd_acc | i_acc) r_next = R_ADDR;
         R_ADDR: begin
            bus.arvalid = 1'b1;
            if (bus.arready) r_next = R_DATA;
         end
         R_DATA: begin
            bus.rready = 1'b1;
            if (bus.rvalid) begin
               r_hit  = 1'b1;
               r_next = R_IDLE;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign bus.inst_sram_addr_ok = i_acc;
   assign bus.data_sram_addr_ok = d_rd_acc | d_wr_acc;
   assign bus.inst_sram_data_ok = r_hit & ~r_owner_data;
   assign bus.data_sram_data_ok = (r_hit & r_owner_data) | w_done;
   assign bus.inst_sram_rdata   = bus.rdata;
   assign bus.data_sram_rdata   = bus.rdata;

   assign bus.arid    = r_owner_data ? DATA_ID : INST_ID;
   assign bus.araddr  = r_addr;
   assign bus.arsize  = axi_size(r_size);
   assign bus.arlen   = AXI_LEN;
   assign bus.arburst = AXI_BURST;
   assign bus.arlock  = AXI_LOCK;
   assign bus.arcache = AXI_CACHE;
   assign bus.arprot  = AXI_PROT;

   assign bus.awid    = DATA_ID;
   assign bus.wid     = DATA_ID;
   assign bus.wlast   = 1'b1;
   assign bus.awlen   = AXI_LEN;
   assign bus.awburst = AXI_BURST;
   assign bus.awlock  = AXI_LOCK;
   assign bus.awcache = AXI_CACHE;
   assign bus.awprot  = AXI_PROT;

   sram_axi_bridge_axi_wr_ctrl u_wr (
      .clk       (clk),
      .reset     (reset),
      .acc       (d_wr_acc),
      .req_addr  (bus.data_sram_addr),
      .req_size  (bus.data_sram_size),
      .req_wstrb (bus.data_sram_wstrb),
      .req_wdata (bus.data_sram_wdata),
      .idle      (w_idle),
      .done      (w_done),
      .awaddr    (bus.awaddr),
      .awsize    (bus.awsize),
      .awvalid   (bus.awvalid),
      .awready   (bus.awready),
      .wdata     (bus.wdata),
      .wstrb     (bus.wstrb),
      .wvalid    (bus.wvalid),
      .wready    (bus.wready),
      .bvalid    (bus.bvalid),
      .bready    (bus.bready)
   );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a per-cycle transaction-level reference model.
module tb_sram_axi_bridge;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   sram_axi_bridge_if bus();

   sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.inst_sram_req   = 1'b0;
      bus.inst_sram_size  = 2'd2;
      bus.inst_sram_addr  = '0;
      bus.data_sram_req   = 1'b0;
      bus.data_sram_wr    = 1'b0;
      bus.data_sram_size  = 2'd2;
      bus.data_sram_wstrb = '0;
      bus.data_sram_addr  = '0;
      bus.data_sram_wdata = '0;
      bus.arready = 1'b0;
      bus.rid     = '0;
      bus.rdata   = '0;
      bus.rresp   = '0;
      bus.rlast   = 1'b1;
      bus.rvalid  = 1'b0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bid     = '0;
      bus.bresp   = '0;
      bus.bvalid  = 1'b0;
   endtask

   // Reference model: at most one read and one write transaction, tracked by phase.
   bit          m_rd, m_rd_data, m_ar_done;
   logic [31:0] m_rd_addr;
   logic [1:0]  m_rd_size;
   bit          m_wr, m_aw_done, m_w_done;
   logic [31:0] m_wr_addr, m_wr_data;
   logic [1:0]  m_wr_size;
   logic [3:0]  m_wr_strb;

   always @(negedge clk) begin
      logic e_drd, e_dwr, e_i, e_arv, e_rr, rhit, e_awv, e_wv, e_br, bhit;
      if (reset) begin
         m_rd = 0; m_wr = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
         chk("reset_quiet",
             {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
              bus.inst_sram_addr_ok, bus.data_sram_addr_ok,
              bus.inst_sram_data_ok, bus.data_sram_data_ok}, '0);
      end else begin
         e_drd = bus.data_sram_req & ~bus.data_sram_wr & ~m_rd & ~m_wr;
         e_dwr = bus.data_sram_req & bus.data_sram_wr & ~m_wr & ~(m_rd & m_rd_data);
         e_i   = bus.inst_sram_req & ~m_rd & ~e_drd;
         e_arv = m_rd & ~m_ar_done;
         e_rr  = m_rd & m_ar_done;
         rhit  = e_rr & bus.rvalid;
         e_awv = m_wr & ~m_aw_done;
         e_wv  = m_wr & ~m_w_done;
         e_br  = m_wr & m_aw_done & m_w_done;
         bhit  = e_br & bus.bvalid;

         chk("m_inst_addr_ok", bus.inst_sram_addr_ok, e_i);
         chk("m_data_addr_ok", bus.data_sram_addr_ok, e_drd | e_dwr);
         chk("m_arvalid", bus.arvalid, e_arv);
         if (e_arv)
            chk("m_ar_payload", {bus.arid, bus.arsize, bus.araddr},
                {(m_rd_data ? 4'd1 : 4'd0), {1'b0, m_rd_size}, m_rd_addr});
         chk("m_rready", bus.rready, e_rr);
         chk("m_inst_data_ok", bus.inst_sram_data_ok, rhit & ~m_rd_data);
         chk("m_data_data_ok", bus.data_sram_data_ok, (rhit & m_rd_data) | bhit);
         if (rhit & ~m_rd_data) chk("m_inst_rdata", bus.inst_sram_rdata, bus.rdata);
         if (rhit & m_rd_data)  chk("m_data_rdata", bus.data_sram_rdata, bus.rdata);
         chk("m_awvalid", bus.awvalid, e_awv);
         chk("m_wvalid", bus.wvalid, e_wv);
         chk("m_bready", bus.bready, e_br);
         if (e_awv)
            chk("m_aw_payload", {bus.awid, bus.awsize, bus.awaddr},
                {4'd1, {1'b0, m_wr_size}, m_wr_addr});
         if (e_wv)
            chk("m_w_payload", {bus.wid, bus.wstrb, bus.wlast, bus.wdata},
                {4'd1, m_wr_strb, 1'b1, m_wr_data});

         if (rhit) m_rd = 0;
         else if (e_arv & bus.arready) m_ar_done = 1;
         if (e_drd | e_i) begin
            m_rd      = 1;
            m_ar_done = 0;
            m_rd_data = e_drd;
            m_rd_addr = e_drd ? bus.data_sram_addr : bus.inst_sram_addr;
            m_rd_size = e_drd ? bus.data_sram_size : bus.inst_sram_size;
         end
         if (bhit) m_wr = 0;
         if (e_awv & bus.awready) m_aw_done = 1;
         if (e_wv & bus.wready) m_w_done = 1;
         if (e_dwr) begin
            m_wr      = 1;
            m_aw_done = 0;
            m_w_done  = 0;
            m_wr_addr = bus.data_sram_addr;
            m_wr_size = bus.data_sram_size;
            m_wr_strb = bus.data_sram_wstrb;
            m_wr_data = bus.data_sram_wdata;
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle_inputs();
      tick();
      bus.inst_sram_req = 1'b1;
      bus.data_sram_req = 1'b1;
      #1;
      chk("rst_addr_ok", {bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 2'b00);
      chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 5'b0);
      chk("rst_data_ok", {bus.inst_sram_data_ok, bus.data_sram_data_ok}, 2'b00);
      chk("axi_consts", {bus.arlen, bus.awlen, bus.arburst, bus.awburst, bus.arlock, bus.awlock,
                         bus.arcache, bus.awcache, bus.arprot, bus.awprot},
          {8'd0, 8'd0, 2'b01, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 3'd0, 3'd0});
      tick();
      idle_inputs();
      reset = 1'b0;
      tick();

      // Single fetch, minimum latency
      bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hBFC00000; bus.arready = 1'b1;
      #1 chk("t1_addr_ok", bus.inst_sram_addr_ok, 1'b1);
      tick();
      bus.inst_sram_req = 1'b0;
      #1 chk("t1_ar", {bus.arvalid, bus.arid, bus.araddr, bus.arsize}, {1'b1, 4'd0, 32'hBFC00000, 3'b010});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h3C1D0001;
      #1 chk("t1_data_ok", {bus.inst_sram_data_ok, bus.data_sram_data_ok, bus.inst_sram_rdata},
             {1'b1, 1'b0, 32'h3C1D0001});
      tick();
      bus.rvalid = 1'b0;

      // Same-cycle inst and data read: data wins
      bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hBFC00004;
      bus.data_sram_req = 1'b1; bus.data_sram_addr = 32'h80001000;
      #1 chk("t2_arb", {bus.data_sram_addr_ok, bus.inst_sram_addr_ok}, 2'b10);
      tick();
      bus.data_sram_req = 1'b0; bus.arready = 1'b1;
      #1 chk("t2_ar_data", {bus.inst_sram_addr_ok, bus.arvalid, bus.arid, bus.araddr},
             {1'b0, 1'b1, 4'd1, 32'h80001000});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hA5A55A5A;
      #1 chk("t2_d_data_ok", {bus.data_sram_data_ok, bus.inst_sram_addr_ok, bus.data_sram_rdata},
             {1'b1, 1'b0, 32'hA5A55A5A});
      tick();
      bus.rvalid = 1'b0;
      #1 chk("t2_inst_acc", bus.inst_sram_addr_ok, 1'b1);
      tick();
      bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
      #1 chk("t2_ar_inst", {bus.arid, bus.araddr}, {4'd0, 32'hBFC00004});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h11112222;
      #1 chk("t2_i_data_ok", bus.inst_sram_data_ok, 1'b1);
      tick();
      bus.rvalid = 1'b0;

      // Write with AW delayed, W immediate
      bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_size = 2'd1;
      bus.data_sram_addr = 32'h1FAF0000; bus.data_sram_wdata = 32'h12345678;
      bus.data_sram_wstrb = 4'b0011;
      #1 chk("t3_addr_ok", bus.data_sram_addr_ok, 1'b1);
      tick();
      bus.data_sram_req = 1'b0; bus.wready = 1'b1;
      #1 chk("t3_aw_w", {bus.awvalid, bus.wvalid, bus.awaddr, bus.awsize, bus.wdata, bus.wstrb},
             {1'b1, 1'b1, 32'h1FAF0000, 3'b001, 32'h12345678, 4'b0011});
      tick();
      bus.wready = 1'b0;
      #1 chk("t3_w_dropped", {bus.awvalid, bus.wvalid}, 2'b10);
      tick();
      #1 chk("t3_aw_held", bus.awvalid, 1'b1);
      tick();
      bus.awready = 1'b1;
      #1 chk("t3_aw_last", {bus.awvalid, bus.bready, bus.data_sram_data_ok}, 3'b100);
      tick();
      bus.awready = 1'b0;
      #1 chk("t3_resp_wait", {bus.awvalid, bus.bready, bus.data_sram_data_ok}, 3'b010);
      tick();
      bus.bvalid = 1'b1;
      #1 chk("t3_data_ok", bus.data_sram_data_ok, 1'b1);
      tick();
      bus.bvalid = 1'b0;
      #1 chk("t3_idle", {bus.data_sram_data_ok, bus.bready}, 2'b00);

      // Write outstanding, then data read blocked, inst fetch proceeds
      bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b1; bus.data_sram_size = 2'd2;
      bus.data_sram_addr = 32'h00002000; bus.data_sram_wdata = 32'hCAFEF00D;
      bus.data_sram_wstrb = 4'hF;
      #1 chk("t4_wr_acc", bus.data_sram_addr_ok, 1'b1);
      tick();
      bus.data_sram_wr = 1'b0; bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hBFC00010;
      bus.awready = 1'b1; bus.wready = 1'b1;
      #1 chk("t4_raw_block", {bus.data_sram_addr_ok, bus.inst_sram_addr_ok}, 2'b01);
      tick();
      bus.inst_sram_req = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b1;
      #1 chk("t4_inst_ar", {bus.data_sram_addr_ok, bus.arvalid, bus.arid, bus.bready}, {1'b0, 1'b1, 4'd0, 1'b1});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0BADBEEF;
      #1 chk("t4_inst_done", {bus.inst_sram_data_ok, bus.data_sram_addr_ok, bus.inst_sram_rdata},
             {1'b1, 1'b0, 32'h0BADBEEF});
      tick();
      bus.rvalid = 1'b0; bus.bvalid = 1'b1;
      #1 chk("t4_bvalid", {bus.data_sram_data_ok, bus.data_sram_addr_ok}, 2'b10);
      tick();
      bus.bvalid = 1'b0;
      #1 chk("t4_rd_acc", bus.data_sram_addr_ok, 1'b1);
      tick();
      bus.data_sram_req = 1'b0; bus.arready = 1'b1;
      #1 chk("t4_rd_ar", {bus.arvalid, bus.arid, bus.araddr}, {1'b1, 4'd1, 32'h00002000});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h76543210;
      #1 chk("t4_rd_done", {bus.data_sram_data_ok, bus.data_sram_rdata}, {1'b1, 32'h76543210});
      tick();
      bus.rvalid = 1'b0;

      // Read outstanding, then data write blocked until rvalid has passed
      bus.data_sram_req = 1'b1; bus.data_sram_wr = 1'b0; bus.data_sram_addr = 32'h00003000;
      #1 chk("t5_rd_acc", bus.data_sram_addr_ok, 1'b1);
      tick();
      bus.data_sram_wr = 1'b1; bus.data_sram_addr = 32'h00003004;
      bus.data_sram_wdata = 32'h55AA55AA; bus.data_sram_wstrb = 4'hF; bus.arready = 1'b1;
      #1 chk("t5_war_block", {bus.data_sram_addr_ok, bus.arvalid}, 2'b01);
      tick();
      bus.arready = 1'b0;
      #1 chk("t5_war_block2", {bus.data_sram_addr_ok, bus.rready}, 2'b01);
      tick();
      bus.rvalid = 1'b1; bus.rdata = 32'h13572468;
      #1 chk("t5_rvalid", {bus.data_sram_data_ok, bus.data_sram_addr_ok}, 2'b10);
      tick();
      bus.rvalid = 1'b0;
      #1 chk("t5_wr_acc", {bus.data_sram_addr_ok, bus.data_sram_data_ok}, 2'b10);
      tick();
      bus.data_sram_req = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
      #1 chk("t5_aw", {bus.awvalid, bus.awaddr, bus.wdata}, {1'b1, 32'h00003004, 32'h55AA55AA});
      tick();
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
      #1 chk("t5_b", bus.data_sram_data_ok, 1'b1);
      tick();
      bus.bvalid = 1'b0;
      #1 chk("t5_idle", bus.data_sram_data_ok, 1'b0);

      // Asynchronous reset while arvalid is high
      bus.inst_sram_req = 1'b1; bus.inst_sram_addr = 32'hBFC00020;
      #1 chk("t6_acc", bus.inst_sram_addr_ok, 1'b1);
      tick();
      #1 chk("t6_arvalid", bus.arvalid, 1'b1);
      reset = 1'b1;
      #1 chk("t6_async", {bus.arvalid, bus.rready, bus.inst_sram_addr_ok, bus.data_sram_addr_ok}, 4'b0000);
      tick();
      reset = 1'b0;
      #1 chk("t6_idle_acc", bus.inst_sram_addr_ok, 1'b1);
      tick();
      bus.inst_sram_req = 1'b0; bus.arready = 1'b1;
      #1 chk("t6_ar", {bus.arvalid, bus.araddr}, {1'b1, 32'hBFC00020});
      tick();
      bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hDEADC0DE;
      #1 chk("t6_done", {bus.inst_sram_data_ok, bus.inst_sram_rdata}, {1'b1, 32'hDEADC0DE});
      tick();
      idle_inputs();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
